// File: rtl/minesweeper_pkg.sv
// Shared board geometry, fill-state encoding and tile index helpers for the
// Minesweeper datapath blocks.
package minesweeper_pkg;

  localparam int GRID_SIZE   = 8;
  localparam int TOTAL_TILES = GRID_SIZE * GRID_SIZE;
  localparam int INDEX_BITS  = $clog2(TOTAL_TILES);

  typedef logic [INDEX_BITS-1:0]  tile_idx_t;
  typedef logic [TOTAL_TILES-1:0] tile_mask_t;

  typedef enum logic [1:0] {
    StIdle,
    StSeed,
    StScan,
    StApply
  } fill_state_e;

  function automatic int idx_row(tile_idx_t idx);
    return int'(idx) / GRID_SIZE;
  endfunction

  function automatic int idx_col(tile_idx_t idx);
    return int'(idx) % GRID_SIZE;
  endfunction

  function automatic logic in_grid(int r, int c);
    return (r >= 0) && (r < GRID_SIZE) && (c >= 0) && (c < GRID_SIZE);
  endfunction

  // Only meaningful when in_grid(r, c) holds; callers guard with it.
  function automatic tile_idx_t rc_to_idx(int r, int c);
    return tile_idx_t'(r * GRID_SIZE + c);
  endfunction

endpackage

// File: rtl/zero_neighbour_map.sv
// Combinational map of tiles with no mine among their in-grid neighbours.
// Neighbours are taken by (row, col) so nothing wraps across a row edge.
module zero_neighbour_map
  import minesweeper_pkg::*;
(
  input  logic [TOTAL_TILES-1:0] mines_i,
  output logic [TOTAL_TILES-1:0] zmask_o
);

  always_comb begin
    zmask_o = '1;
    for (int j = 0; j < TOTAL_TILES; j++) begin
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if ((dr != 0 || dc != 0) &&
              in_grid(idx_row(tile_idx_t'(j)) + dr, idx_col(tile_idx_t'(j)) + dc)) begin
            if (mines_i[rc_to_idx(idx_row(tile_idx_t'(j)) + dr,
                                  idx_col(tile_idx_t'(j)) + dc)]) begin
              zmask_o[j] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/flood_fill_engine.sv
// Reveal flood fill: sweeps the board one tile per cycle until a sweep adds
// nothing, then presents the mask with a one-cycle apply pulse.
module flood_fill_engine
  import minesweeper_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [INDEX_BITS-1:0]  start_index_i,
  input  logic [TOTAL_TILES-1:0] mines_i,
  input  logic [TOTAL_TILES-1:0] flagged_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic [TOTAL_TILES-1:0] flood_update_o,
  output logic                   flood_apply_o
);

  fill_state_e state_q, state_d;
  tile_mask_t  mask_q, mask_d;
  tile_mask_t  fsnap_q, fsnap_d;
  tile_mask_t  update_q, update_d;
  tile_idx_t   seed_q, seed_d;
  tile_idx_t   cursor_q, cursor_d;
  logic        changed_q, changed_d;

  tile_mask_t  zmask;
  tile_mask_t  exp_mask;
  int          cur_row;
  int          cur_col;
  logic        nbr_hit;
  logic        add_tile;

  zero_neighbour_map u_zero_map (
    .mines_i (mines_i),
    .zmask_o (zmask)
  );

  assign exp_mask = mask_q & zmask & ~mines_i;
  assign cur_row  = idx_row(cursor_q);
  assign cur_col  = idx_col(cursor_q);

  always_comb begin
    nbr_hit = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && in_grid(cur_row + dr, cur_col + dc)) begin
          nbr_hit = nbr_hit | exp_mask[rc_to_idx(cur_row + dr, cur_col + dc)];
        end
      end
    end
  end

  assign add_tile = ~mask_q[cursor_q] & ~mines_i[cursor_q] & ~fsnap_q[cursor_q] & nbr_hit;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    fsnap_d   = fsnap_q;
    seed_d    = seed_q;
    cursor_d  = cursor_q;
    changed_d = changed_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d  = '0;
          fsnap_d = flagged_i;
          seed_d  = start_index_i;
          state_d = StSeed;
        end
      end
      StSeed: begin
        if (mines_i[seed_q] || fsnap_q[seed_q]) begin
          mask_d  = '0;
          state_d = StApply;
        end else begin
          mask_d[seed_q] = 1'b1;
          if (!zmask[seed_q]) begin
            state_d = StApply;
          end else begin
            cursor_d  = '0;
            changed_d = 1'b0;
            state_d   = StScan;
          end
        end
      end
      StScan: begin
        if (add_tile) begin
          mask_d[cursor_q] = 1'b1;
          changed_d        = 1'b1;
        end
        if (cursor_q == tile_idx_t'(TOTAL_TILES - 1)) begin
          if (changed_q || add_tile) begin
            cursor_d  = '0;
            changed_d = 1'b0;
          end else begin
            state_d = StApply;
          end
        end else begin
          cursor_d = cursor_q + tile_idx_t'(1);
        end
      end
      StApply: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Load the result on entry to APPLY so the mask and the pulse line up.
  always_comb begin
    update_d = update_q;
    if ((state_d == StApply) && (state_q != StApply)) begin
      update_d = mask_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      fsnap_q   <= '0;
      update_q  <= '0;
      seed_q    <= '0;
      cursor_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      fsnap_q   <= fsnap_d;
      update_q  <= update_d;
      seed_q    <= seed_d;
      cursor_q  <= cursor_d;
      changed_q <= changed_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign flood_apply_o  = (state_q == StApply);
  assign flood_update_o = update_q;

endmodule

// File: tb/tb_flood_fill_engine.sv
// Directed bench for flood_fill_engine: hand-computed masks and apply latencies.
module tb_flood_fill_engine;
  import minesweeper_pkg::*;

  logic                   clk_i;
  logic                   rst_ni;
  logic                   start_i;
  logic [INDEX_BITS-1:0]  start_index_i;
  logic [TOTAL_TILES-1:0] mines_i;
  logic [TOTAL_TILES-1:0] flagged_i;
  logic                   abort_i;
  logic                   busy_o;
  logic [TOTAL_TILES-1:0] flood_update_o;
  logic                   flood_apply_o;

  int n_checks;
  int n_errors;
  int cyc;
  int n_start;
  int lat;
  logic got;
  logic saw;
  logic [TOTAL_TILES-1:0] col7;

  flood_fill_engine dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .start_index_i  (start_index_i),
    .mines_i        (mines_i),
    .flagged_i      (flagged_i),
    .abort_i        (abort_i),
    .busy_o         (busy_o),
    .flood_update_o (flood_update_o),
    .flood_apply_o  (flood_apply_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_fill(input int idx);
    @(negedge clk_i);
    start_index_i = tile_idx_t'(idx);
    start_i       = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    n_start = cyc;
  endtask

  // Latency in cycles from the start-sampling cycle to the apply cycle.
  task automatic wait_apply(input int limit, output int l, output logic seen);
    seen = 1'b0;
    l    = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (flood_apply_o) begin
        seen = 1'b1;
        l    = cyc - n_start + 1;
        break;
      end
    end
  endtask

  task automatic watch_no_apply(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (flood_apply_o) seen = 1'b1;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    start_index_i = '0;
    mines_i       = '0;
    flagged_i     = '0;
    abort_i       = 1'b0;
    col7          = '0;
    for (int r = 0; r < GRID_SIZE; r++) col7[r*GRID_SIZE + 7] = 1'b1;

    repeat (3) @(negedge clk_i);
    check_eq("reset_busy", 64'(busy_o), 64'd0);
    check_eq("reset_update", flood_update_o, 64'd0);
    check_eq("reset_apply", 64'(flood_apply_o), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Empty board from a corner: two sweeps.
    start_fill(0);
    wait_apply(5000, lat, got);
    check_eq("t1_seen", 64'(got), 64'd1);
    check_eq("t1_lat", 64'(lat), 64'd130);
    check_eq("t1_mask", flood_update_o, {64{1'b1}});
    @(negedge clk_i);
    check_eq("t1_busy_low", 64'(busy_o), 64'd0);
    check_eq("t1_apply_low", 64'(flood_apply_o), 64'd0);

    // Mine at 9: tiles 0, 1, 8 touch only nonzero tiles, so stay hidden.
    mines_i = 64'h0000_0000_0000_0200;
    start_fill(63);
    wait_apply(20000, lat, got);
    check_eq("t2_seen", 64'(got), 64'd1);
    check_eq("t2_mask", flood_update_o, 64'hFFFF_FFFF_FFFF_FCFC);

    start_fill(0);
    wait_apply(5000, lat, got);
    check_eq("t3_lat", 64'(lat), 64'd2);
    check_eq("t3_mask", flood_update_o, 64'h1);

    start_fill(9);
    wait_apply(5000, lat, got);
    check_eq("t4_mine_lat", 64'(lat), 64'd2);
    check_eq("t4_mine_mask", flood_update_o, 64'h0);

    mines_i   = '0;
    flagged_i = 64'h0000_0000_0010_0000;
    start_fill(20);
    flagged_i = '0;
    wait_apply(5000, lat, got);
    check_eq("t4_flag_lat", 64'(lat), 64'd2);
    check_eq("t4_flag_mask", flood_update_o, 64'h0);

    start_fill(0);
    repeat (4) @(negedge clk_i);
    flagged_i = 64'h0000_0100_0000_0000;
    wait_apply(5000, lat, got);
    flagged_i = '0;
    check_eq("t4_late_flag_lat", 64'(lat), 64'd130);
    check_eq("t4_late_flag_mask", flood_update_o, {64{1'b1}});

    mines_i = col7;
    start_fill(0);
    wait_apply(20000, lat, got);
    check_eq("t5_seen", 64'(got), 64'd1);
    check_eq("t5_mask", flood_update_o, 64'h7F7F_7F7F_7F7F_7F7F);

    // Abort mid-scan keeps the previous result.
    mines_i = '0;
    start_fill(0);
    repeat (20) @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check_eq("t6_abort_busy", 64'(busy_o), 64'd0);
    watch_no_apply(200, saw);
    check_eq("t6_abort_no_apply", 64'(saw), 64'd0);
    check_eq("t6_abort_keep", flood_update_o, 64'h7F7F_7F7F_7F7F_7F7F);

    // Start and abort together in IDLE: start wins.
    @(negedge clk_i);
    start_index_i = '0;
    start_i       = 1'b1;
    abort_i       = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    n_start = cyc;
    @(negedge clk_i);
    check_eq("t6_start_abort_busy", 64'(busy_o), 64'd1);
    wait_apply(5000, lat, got);
    check_eq("t6_start_abort_lat", 64'(lat), 64'd130);

    // Second start while busy is ignored.
    @(negedge clk_i);
    start_fill(0);
    repeat (9) @(negedge clk_i);
    start_index_i = 6'd63;
    flagged_i     = {64{1'b1}};
    start_i       = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
    flagged_i = '0;
    wait_apply(5000, lat, got);
    check_eq("t6_busy_start_lat", 64'(lat), 64'd130);
    check_eq("t6_busy_start_mask", flood_update_o, {64{1'b1}});

    // Asynchronous reset mid-scan.
    @(negedge clk_i);
    start_fill(0);
    repeat (20) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("t6_rst_busy", 64'(busy_o), 64'd0);
    check_eq("t6_rst_update", flood_update_o, 64'd0);
    check_eq("t6_rst_apply", 64'(flood_apply_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    watch_no_apply(200, saw);
    check_eq("t6_rst_no_apply", 64'(saw), 64'd0);
    check_eq("t6_rst_update_hold", flood_update_o, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
